// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU execution controller and anything that
// decodes its state (LED/seven-segment display logic).
//   state_t             : 2-bit FSM encoding IDLE=0, RUN=1, STEP=2, BREAK=3
//   DEBOUNCE_CYCLES_DEF : default hold time for debounced board buttons
//   DIV_CYCLES_DEF      : default clk cycles per cpu_en pulse in RUN
//   CNT_W_DEF           : default width of the retired-cycle counter
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int DIV_CYCLES_DEF      = 4;
  localparam int CNT_W_DEF           = 32;

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_exec_ctrl_if
// Bundles the board-side controls, the IF-stage PC and the controller outputs.
//   master : board/CPU-top side; drives run, step, bp_en, bp_addr, pc_if and
//            observes cpu_en, halted, state, cycle_cnt
//   slave  : the execution controller itself
// CNT_W must match the CNT_W of the attached cpu_exec_ctrl.
// -----------------------------------------------------------------------------
interface cpu_exec_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc_if;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output run, step, bp_en, bp_addr, pc_if,
    input  cpu_en, halted, state, cycle_cnt
  );

  modport slave (
    input  run, step, bp_en, bp_addr, pc_if,
    output cpu_en, halted, state, cycle_cnt
  );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions a raw, bouncy, asynchronous push-button into a single-clk pulse.
//   clk     : sampling clock
//   rst     : asynchronous active-high reset
//   i_btn   : raw button level (asynchronous to clk)
//   o_pulse : 1-clk pulse when the accepted level goes 0->1
// The synchronised level must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted; any match
// restarts the count. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles.
// -----------------------------------------------------------------------------
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int HOLD_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]        r_sync;
  logic [HOLD_W-1:0] r_hold;
  logic              r_level;
  logic              r_pulse;

  // Synchroniser, hold counter, accepted level and rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_hold  <= {HOLD_W{1'b0}};
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (r_sync[1] != r_level) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle
        if (r_hold == HOLD_MAX) begin
          r_level <= r_sync[1];
          r_hold  <= {HOLD_W{1'b0}};
          r_pulse <= r_sync[1];
        end else begin
          r_hold  <= r_hold + HOLD_W'(1);
        end
      end else begin
        r_hold <= {HOLD_W{1'b0}};
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_exec_ctrl
// Execution controller for the 5-stage MIPS core. Produces a single
// clock-enable pulse (cpu_en) that gates every pipeline register, the PC and
// the regfile/RAM write ports.
//   clk   : board clock, sole clock of the CPU
//   reset : asynchronous active-high reset
//   bus   : cpu_exec_ctrl_if.slave
//           run/step/bp_en/bp_addr/pc_if in; cpu_en/halted/state/cycle_cnt out
// Modes: free-run with a DIV_CYCLES divider, debounced single-step, and a
// PC breakpoint that can be stepped over from BREAK.
// -----------------------------------------------------------------------------
module cpu_exec_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DIV_CYCLES      = DIV_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  cpu_exec_ctrl_if.slave bus
);

  localparam int DIV_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_CYCLES - 1);

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic w_step_pulse;
  logic w_tick;
  logic w_bp_hit;
  logic w_cpu_en;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk    (clk),
    .rst    (reset),
    .i_btn  (bus.step),
    .o_pulse(w_step_pulse)
  );

  assign w_tick   = (r_state == ST_RUN) && (r_div == DIV_MAX);
  assign w_bp_hit = bus.bp_en && (bus.pc_if == bus.bp_addr);

  // cpu_en decode: only registered state plus stable inputs, settled well
  // before the next clk edge; the core uses it strictly as an enable.
  always_comb begin
    w_cpu_en = 1'b0;
    case (r_state)
      ST_STEP: w_cpu_en = 1'b1;
      ST_RUN: begin
        if (bus.run && w_tick && !w_bp_hit) begin
          w_cpu_en = 1'b1;
        end else begin
          w_cpu_en = 1'b0;
        end
      end
      // Step-over: run=0 in the same cycle wins and suppresses the pulse
      ST_BREAK: begin
        if (bus.run && w_step_pulse) begin
          w_cpu_en = 1'b1;
        end else begin
          w_cpu_en = 1'b0;
        end
      end
      default: w_cpu_en = 1'b0;
    endcase
  end

  // Control FSM with divider and registered halted flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_div    <= {DIV_W{1'b0}};
      r_halted <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_div <= {DIV_W{1'b0}};
          if (bus.run) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else if (w_step_pulse) begin
            r_state  <= ST_STEP;
            r_halted <= 1'b0;
          end else begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b1;
          end
        end
        // The breakpoint is deliberately not checked here
        ST_STEP: begin
          r_state  <= ST_IDLE;
          r_halted <= 1'b1;
          r_div    <= {DIV_W{1'b0}};
        end
        ST_RUN: begin
          if (!bus.run) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b1;
            r_div    <= {DIV_W{1'b0}};
          end else if (w_tick) begin
            r_div <= {DIV_W{1'b0}};
            if (w_bp_hit) begin
              r_state  <= ST_BREAK;
              r_halted <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_halted <= 1'b0;
            end
          end else begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_div    <= r_div + DIV_W'(1);
          end
        end
        // Re-entering RUN with divider=0 puts the next breakpoint check
        // DIV_CYCLES cycles out, after pc_if has moved past bp_addr
        ST_BREAK: begin
          r_div <= {DIV_W{1'b0}};
          if (!bus.run) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b1;
          end else if (w_step_pulse) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else begin
            r_state  <= ST_BREAK;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_halted <= 1'b1;
          r_div    <= {DIV_W{1'b0}};
        end
      endcase
    end
  end

  // Retired-cycle counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= {CNT_W{1'b0}};
    end else if (w_cpu_en) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end else begin
      r_cycle_cnt <= r_cycle_cnt;
    end
  end

  assign bus.cpu_en    = w_cpu_en;
  assign bus.halted    = r_halted;
  assign bus.state     = r_state;
  assign bus.cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_exec_ctrl
// Self-checking bench for cpu_exec_ctrl with DEBOUNCE_CYCLES=4, DIV_CYCLES=4.
// Expected cpu_en cycles are pushed to a queue when stimulus is applied and
// popped when a pulse is seen. A second instance with CNT_W=3 exercises the
// counter wrap. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_exec_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_q[$];
  logic [2:0] cnt_q[$];
  logic [31:0] exp_cnt;
  logic pc_pend;

  cpu_exec_ctrl_if #(.CNT_W(32)) bus ();
  cpu_exec_ctrl_if #(.CNT_W(3))  bus_w ();

  cpu_exec_ctrl #(.DEBOUNCE_CYCLES(4), .DIV_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  cpu_exec_ctrl #(.DEBOUNCE_CYCLES(4), .DIV_CYCLES(4), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 32'd0;
    pc_pend = 1'b0;
  endtask

  // Reset values, then reset asserted mid-RUN with cycle_cnt=7
  task automatic test_reset();
    int t0;
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b want 0", bus.cpu_en); end
    n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %b want 1", bus.halted); end
    n_tests++; if (bus.cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.cycle_cnt); end
    @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b1;
    t0 = cyc;
    repeat (30) @(negedge clk);
    n_tests++; if (bus.cycle_cnt !== 32'd7) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d want 7 (t0=%0d)", bus.cycle_cnt, t0); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL midrun_reset_state: got %0d want 0", bus.state); end
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_en: got %b want 0", bus.cpu_en); end
    n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL midrun_reset_halted: got %b want 1", bus.halted); end
    n_tests++; if (bus.cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_cnt: got %0d want 0", bus.cycle_cnt); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL release_en: got %b want 0", bus.cpu_en); end
    @(negedge clk);
    n_tests++; if (bus.cpu_en !== 1'b0 || bus.state !== 2'd1) begin n_fail++; $display("FAIL release_run: en=%b state=%0d want en=0 state=1", bus.cpu_en, bus.state); end
    bus.run = 1'b0;
    repeat (3) @(negedge clk);
    exp_cnt = 32'd0;
  endtask

  // Free run: pulse every 4th cycle, 10 pulses, then drop run
  task automatic test_run();
    int t0;
    int e;
    bus.bp_en = 1'b0;
    bus.run = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 10; i++) exp_q.push_back(t0 + 4 * i);
    exp_cnt = exp_cnt + 32'd10;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      if (bus.cpu_en === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL run_pulse: unexpected cpu_en at cycle %0d, want none", cyc); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL run_pulse: cpu_en at cycle %0d want %0d", cyc, e); end end
      end
      if (k == 40) bus.run = 1'b0;
      if (k == 41) begin
        n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL run_stop_state: got %0d want 0", bus.state); end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL run_missing: %0d pulses outstanding want 0", exp_q.size()); end
    n_tests++; if (bus.cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL run_cnt: got %0d want %0d", bus.cycle_cnt, exp_cnt); end
    exp_q.delete();
  endtask

  // Bouncy press 1,0,1 then stable: exactly one step pulse
  task automatic test_step_bounce();
    int s;
    int e;
    @(negedge clk); bus.step = 1'b1;
    @(negedge clk); bus.step = 1'b0;
    @(negedge clk); bus.step = 1'b1;
    s = cyc;
    exp_q.push_back(s + 7);
    exp_cnt = exp_cnt + 32'd1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cpu_en === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL step_pulse: unexpected cpu_en at cycle %0d, want none", cyc); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL step_pulse: cpu_en at cycle %0d want %0d", cyc, e); end end
      end
      if (k == 9) bus.step = 1'b0;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL step_missing: %0d pulses outstanding want 0", exp_q.size()); end
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL step_state: got %0d want 0", bus.state); end
    n_tests++; if (bus.cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL step_cnt: got %0d want %0d", bus.cycle_cnt, exp_cnt); end
    exp_q.delete();
  endtask

  // Breakpoint at 0x10 with pc_if advancing by 4 per cpu_en
  task automatic test_breakpoint();
    int t0;
    int e;
    logic got;
    do_reset();
    bus.pc_if = 32'h0000_0000;
    bus.bp_addr = 32'h0000_0010;
    bus.bp_en = 1'b1;
    bus.run = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 4; i++) exp_q.push_back(t0 + 4 * i);
    exp_cnt = exp_cnt + 32'd4;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      got = bus.cpu_en;
      if (got === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_pulse: unexpected cpu_en at cycle %0d pc=%h", cyc, bus.pc_if); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL bp_pulse: cpu_en at cycle %0d want %0d", cyc, e); end end
      end
      if (pc_pend) bus.pc_if = bus.pc_if + 32'd4;
      pc_pend = got;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_missing: %0d pulses outstanding want 0", exp_q.size()); end
    n_tests++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL bp_state: got %0d want 3", bus.state); end
    n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL bp_halted: got %b want 1", bus.halted); end
    n_tests++; if (bus.cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt: got %0d want %0d", bus.cycle_cnt, exp_cnt); end
    exp_q.delete();
  endtask

  // Step over the breakpoint from BREAK with run held high
  task automatic test_step_over();
    int c;
    int e;
    logic got;
    c = cyc;
    bus.step = 1'b1;
    exp_q.push_back(c + 6);
    exp_q.push_back(c + 10);
    exp_cnt = exp_cnt + 32'd2;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      got = bus.cpu_en;
      if (got === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stepover_pulse: unexpected cpu_en at cycle %0d pc=%h", cyc, bus.pc_if); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL stepover_pulse: cpu_en at cycle %0d want %0d", cyc, e); end end
      end
      if (cyc == c + 7) begin
        n_tests++; if (bus.cycle_cnt !== 32'd5 || bus.state !== 2'd1) begin n_fail++; $display("FAIL stepover_resume: cnt=%0d state=%0d want cnt=5 state=1", bus.cycle_cnt, bus.state); end
      end
      if (pc_pend) bus.pc_if = bus.pc_if + 32'd4;
      pc_pend = got;
      if (k == 11) begin
        bus.run = 1'b0;
        bus.step = 1'b0;
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stepover_missing: %0d pulses outstanding want 0", exp_q.size()); end
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL stepover_state: got %0d want 0", bus.state); end
    n_tests++; if (bus.cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL stepover_cnt: got %0d want %0d", bus.cycle_cnt, exp_cnt); end
    bus.bp_en = 1'b0;
    exp_q.delete();
  endtask

  // run rising together with step_pulse in IDLE: RUN wins, no STEP pulse
  task automatic test_run_priority();
    int c;
    int e;
    c = cyc;
    bus.step = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.cpu_en === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL prio_pulse: unexpected cpu_en at cycle %0d state=%0d", cyc, bus.state); end
        else begin e = exp_q.pop_front(); if (cyc !== e) begin n_fail++; $display("FAIL prio_pulse: cpu_en at cycle %0d want %0d", cyc, e); end end
      end
      if (k == 5) begin
        bus.run = 1'b1;
        exp_q.push_back(c + 10);
        exp_q.push_back(c + 14);
        exp_cnt = exp_cnt + 32'd2;
      end
      if (k == 6) begin
        n_tests++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL prio_state: got %0d want 1", bus.state); end
      end
      if (k == 14) begin
        bus.run = 1'b0;
        bus.step = 1'b0;
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL prio_missing: %0d pulses outstanding want 0", exp_q.size()); end
    n_tests++; if (bus.cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL prio_cnt: got %0d want %0d", bus.cycle_cnt, exp_cnt); end
    exp_q.delete();
  endtask

  // Counter wrap on the 3-bit instance: ...,6,7,0,1
  task automatic test_cnt_wrap();
    logic prev_en;
    logic [2:0] e;
    prev_en = 1'b0;
    bus_w.run = 1'b1;
    for (int i = 1; i <= 9; i++) cnt_q.push_back(3'(i));
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      if (prev_en) begin
        n_tests++;
        if (cnt_q.size() == 0) begin n_fail++; $display("FAIL wrap_cnt: extra pulse, cnt=%0d", bus_w.cycle_cnt); end
        else begin e = cnt_q.pop_front(); if (bus_w.cycle_cnt !== e) begin n_fail++; $display("FAIL wrap_cnt: got %0d want %0d", bus_w.cycle_cnt, e); end end
      end
      prev_en = bus_w.cpu_en;
    end
    bus_w.run = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (cnt_q.size() != 0) begin n_fail++; $display("FAIL wrap_missing: %0d pulses outstanding want 0", cnt_q.size()); end
    n_tests++; if (bus_w.state !== 2'd0 || bus_w.halted !== 1'b1) begin n_fail++; $display("FAIL wrap_idle: state=%0d halted=%b want 0/1", bus_w.state, bus_w.halted); end
  endtask

  initial begin
    bus.run = 1'b0;   bus.step = 1'b0;   bus.bp_en = 1'b0;
    bus.bp_addr = 32'd0;   bus.pc_if = 32'd0;
    bus_w.run = 1'b0; bus_w.step = 1'b0; bus_w.bp_en = 1'b0;
    bus_w.bp_addr = 32'd0; bus_w.pc_if = 32'd0;
    exp_cnt = 32'd0;
    pc_pend = 1'b0;
    #1 reset = 1'b1;
    #2;
    test_reset();
    test_run();
    test_step_bounce();
    test_breakpoint();
    test_step_over();
    test_run_priority();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
- Execution controller for the 5-stage pipelined MIPS core.
- Replaces the raw run/step clock mux with a single clock-enable pulse, cpu_en. Every pipeline register, the PC and the regfile/RAM write ports advance only on clk edges where cpu_en=1.
- Adds a debounced single-step, a PC breakpoint with step-over, and a retired-cycle counter for board display.
- Sits in the CPU top between the board buttons/switches and the IF/ID/EX/MEM/WB stages.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: clk cycles the synchronised step input must hold a new level before it is accepted.
- DIV_CYCLES, 4: clk cycles per cpu_en pulse in RUN. Must be >= 2.
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk  input  1  board clock; sole clock of the block and of the whole CPU.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level switch; 1 = free-run requested.
- step  input  1  raw, bouncy push-button, asynchronous to clk.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  32  breakpoint PC (word-aligned byte address).
- pc_if  input  32  current IF-stage PC.
- cpu_en  output  1  one-clk pulse; the pipeline advances on this edge.
- halted  output  1  1 in IDLE or BREAK.
- state  output  2  current FSM state, for LEDs.
- cycle_cnt  output  CNT_W  count of cpu_en pulses since reset.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous, active-high.
- Reset values: state=IDLE, cpu_en=0, halted=1, cycle_cnt=0, divider=0, debouncer level=0, synchronisers=0.
- Reset asserted mid-operation: all of the above clear immediately. No cpu_en pulse is issued in the cycle of deassertion.

Step input conditioning:
- step passes through a 2-FF synchroniser.
- The debouncer counts consecutive clk cycles in which the synchronised value differs from the accepted level. When the count reaches DEBOUNCE_CYCLES, the accepted level flips. Any match resets the count.
- step_pulse is a 1-clk pulse on a 0->1 transition of the accepted level. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES clk cycles.

States:
- IDLE=0, RUN=1, STEP=2, BREAK=3.

IDLE:
- run=1 -> RUN. This has priority over step_pulse in the same cycle.
- Else step_pulse -> STEP.

STEP:
- cpu_en=1 for exactly this one cycle, then -> IDLE.
- The breakpoint is not checked, so stepping through bp_addr is always possible.

RUN:
- The divider counts 0..DIV_CYCLES-1 and wraps.
- A tick is the cycle in which divider==DIV_CYCLES-1.
- On a tick: if bp_en=1 and pc_if==bp_addr, cpu_en stays 0 and the next state is BREAK. Otherwise cpu_en=1.
- run=0 -> IDLE next cycle, divider cleared. No cpu_en is issued in that cycle, even if it is a tick.
- step_pulse is ignored in RUN.

BREAK:
- run=0 -> IDLE.
- Else step_pulse -> one cpu_en pulse in that same cycle (step-over), then -> RUN with divider=0. The next check occurs DIV_CYCLES cycles later, after pc_if has moved.
- If both events occur in the same cycle, run=0 wins and no pulse is issued.

Outputs and counter:
- cpu_en is combinational from state/divider/compare and must be glitch-free at the clk edge. The core samples it synchronously as an enable; it is never used as a clock.
- cycle_cnt increments by 1 on every cycle with cpu_en=1 and wraps modulo 2^CNT_W to 0.
- Breakpoint compare is a full 32-bit equality.
- bp_en or bp_addr changing mid-RUN takes effect at the next tick.

Decomposition:
- Shared package cpu_ctrl_pkg holds the state encoding (IDLE/RUN/STEP/BREAK as 2-bit constants) and the default DEBOUNCE_CYCLES and DIV_CYCLES values, so the top and display logic decode state identically.
- One sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES. It contains the synchroniser, hold counter, accepted level and rising-edge pulse, and is reused for any other board button.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and DIV_CYCLES=4.
1. Reset asserted mid-RUN with cycle_cnt=7 -> cpu_en=0, cycle_cnt=0, state=0 and halted=1 within the same cycle, without a clk edge.
2. run=1 for 40 cycles, bp_en=0 -> cpu_en high every 4th cycle (cycles 4,8,...,40 after entry), cycle_cnt=10. Drop run -> state=IDLE next cycle and no further pulses.
3. step bounces 1,0,1 on single cycles, then holds 1 for 10 cycles -> exactly one cpu_en pulse, 2+4+1 cycles after the stable edge, then state=IDLE and cycle_cnt=+1.
4. RUN with bp_en=1, bp_addr=0x0000_0010, pc_if stepping 0x0,0x4,0x8,0xC,0x10 per cpu_en -> 4 pulses, pulse at 0x10 suppressed, state=BREAK, halted=1, cycle_cnt=4.
5. From (4), debounced step with run=1 -> one cpu_en (cycle_cnt=5), state=RUN, next pulse exactly 4 cycles later with pc_if=0x14.
6. In IDLE, run rises in the same cycle as step_pulse -> state=RUN, no STEP pulse. cycle_cnt=0xFFFF_FFFF plus one pulse -> 0.
